writeback_stage_p: RTL and testbench

Registered, parametrised writeback stage for the hybrid ARM/MIPS pipeline. Selects the result from one of NSRC result sources, or from the IO port, and presents it to the register file one cycle after acceptance. IO reads use a request/valid/ack handshake with a bounded timeout; while an IO read is pending the stage stalls the upstream pipeline. It supports flush and holds a sticky IO-error flag.

---
 rtl/writeback_stage_p_if.sv | 42 ++++
 rtl/writeback_stage_p.sv | 175 +++++++++++++++++
 tb/tb_writeback_stage_p.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_p_if.sv
// Writeback stage bus: upstream instruction/result inputs, IO read handshake,
// and register-file outputs. The master drives the inputs and the stage is the slave.
interface writeback_stage_p_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 3,
    parameter int SEL_W = 2,
    parameter int RD_W  = 32
);
    logic                    in_valid;
    logic                    pc_src;
    logic                    reg_write;
    logic                    io_flag;
    logic [SEL_W-1:0]        mem_to_reg;
    logic [NSRC*WIDTH-1:0]   src_data;
    logic [RD_W-1:0]         rd;
    logic                    flush;
    logic [WIDTH-1:0]        io_data;
    logic                    io_valid;
    logic                    io_req;
    logic                    io_ack;
    logic                    stall_req;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [RD_W-1:0]         rd_out;
    logic                    reg_write_out;
    logic                    pc_src_out;
    logic                    io_err;

    modport master (
        output in_valid, pc_src, reg_write, io_flag, mem_to_reg, src_data, rd,
               flush, io_data, io_valid,
        input  io_req, io_ack, stall_req, out_valid, out_data, rd_out,
               reg_write_out, pc_src_out, io_err
    );

    modport slave (
        input  in_valid, pc_src, reg_write, io_flag, mem_to_reg, src_data, rd,
               flush, io_data, io_valid,
        output io_req, io_ack, stall_req, out_valid, out_data, rd_out,
               reg_write_out, pc_src_out, io_err
    );
endinterface

// File: rtl/writeback_stage_p.sv
// Registered writeback stage: picks one of NSRC results (or an IO read result)
// and presents it to the register file one cycle after acceptance. IO reads
// stall the pipeline until data arrives, a flush kills them, or a timeout fires.
module writeback_stage_p #(
    parameter int WIDTH      = 32,
    parameter int NSRC       = 3,
    parameter int SEL_W      = 2,
    parameter int RD_W       = 32,
    parameter int IO_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_stage_p_if.slave   bus
);
    localparam int CNT_W = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        IO_WAIT = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;

    logic              out_valid_r, out_valid_nxt_s;
    logic [WIDTH-1:0]  out_data_r, out_data_nxt_s;
    logic [RD_W-1:0]   rd_out_r, rd_out_nxt_s;
    logic              reg_write_out_r, reg_write_out_nxt_s;
    logic              pc_src_out_r, pc_src_out_nxt_s;
    logic              io_ack_r, io_ack_nxt_s;
    logic              io_err_r, io_err_nxt_s;
    logic              busy_r, busy_nxt_s;

    logic [RD_W-1:0]   rd_lat_r, rd_lat_nxt_s;
    logic              reg_write_lat_r, reg_write_lat_nxt_s;
    logic              pc_src_lat_r, pc_src_lat_nxt_s;

    logic              accept_s;
    logic [WIDTH-1:0]  sel_data_s;

    // Out-of-range selectors yield zero rather than an undefined slice.
    function automatic logic [WIDTH-1:0] select_src(
        input logic [SEL_W-1:0]      sel,
        input logic [NSRC*WIDTH-1:0] srcs
    );
        logic [WIDTH-1:0] res;
        res = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SEL_W'(k)) begin
                res = srcs[k*WIDTH +: WIDTH];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign accept_s   = (state_r == IDLE) && bus.in_valid && !bus.flush;
    assign sel_data_s = select_src(bus.mem_to_reg, bus.src_data);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output decode; flush beats io_valid beats timeout.
    always_comb begin
        state_nxt_s         = state_r;
        cnt_nxt_s           = cnt_r;
        out_valid_nxt_s     = 1'b0;
        out_data_nxt_s      = out_data_r;
        rd_out_nxt_s        = rd_out_r;
        reg_write_out_nxt_s = 1'b0;
        pc_src_out_nxt_s    = 1'b0;
        io_ack_nxt_s        = 1'b0;
        io_err_nxt_s        = io_err_r;
        rd_lat_nxt_s        = rd_lat_r;
        reg_write_lat_nxt_s = reg_write_lat_r;
        pc_src_lat_nxt_s    = pc_src_lat_r;
        case (state_r)
            IDLE: begin
                if (accept_s && bus.io_flag) begin
                    state_nxt_s         = IO_WAIT;
                    cnt_nxt_s           = '0;
                    rd_lat_nxt_s        = bus.rd;
                    reg_write_lat_nxt_s = bus.reg_write;
                    pc_src_lat_nxt_s    = bus.pc_src;
                end else if (accept_s) begin
                    out_valid_nxt_s     = 1'b1;
                    out_data_nxt_s      = sel_data_s;
                    rd_out_nxt_s        = bus.rd;
                    reg_write_out_nxt_s = bus.reg_write;
                    pc_src_out_nxt_s    = bus.pc_src;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IO_WAIT: begin
                cnt_nxt_s = cnt_r + 1'b1;
                if (bus.flush) begin
                    state_nxt_s = IDLE;
                end else if (bus.io_valid) begin
                    state_nxt_s         = IDLE;
                    out_valid_nxt_s     = 1'b1;
                    out_data_nxt_s      = bus.io_data;
                    rd_out_nxt_s        = rd_lat_r;
                    reg_write_out_nxt_s = reg_write_lat_r;
                    pc_src_out_nxt_s    = pc_src_lat_r;
                    io_ack_nxt_s        = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    // Timed-out read retires as a non-writing zero result.
                    state_nxt_s         = IDLE;
                    out_valid_nxt_s     = 1'b1;
                    out_data_nxt_s      = '0;
                    rd_out_nxt_s        = rd_lat_r;
                    reg_write_out_nxt_s = 1'b0;
                    pc_src_out_nxt_s    = pc_src_lat_r;
                    io_err_nxt_s        = 1'b1;
                end else begin
                    state_nxt_s = IO_WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s = (state_nxt_s == IO_WAIT);
    end

    // Registered outputs, timeout counter and latched IO instruction fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r           <= '0;
            out_valid_r     <= 1'b0;
            out_data_r      <= '0;
            rd_out_r        <= '0;
            reg_write_out_r <= 1'b0;
            pc_src_out_r    <= 1'b0;
            io_ack_r        <= 1'b0;
            io_err_r        <= 1'b0;
            busy_r          <= 1'b0;
            rd_lat_r        <= '0;
            reg_write_lat_r <= 1'b0;
            pc_src_lat_r    <= 1'b0;
        end else begin
            cnt_r           <= cnt_nxt_s;
            out_valid_r     <= out_valid_nxt_s;
            out_data_r      <= out_data_nxt_s;
            rd_out_r        <= rd_out_nxt_s;
            reg_write_out_r <= reg_write_out_nxt_s;
            pc_src_out_r    <= pc_src_out_nxt_s;
            io_ack_r        <= io_ack_nxt_s;
            io_err_r        <= io_err_nxt_s;
            busy_r          <= busy_nxt_s;
            rd_lat_r        <= rd_lat_nxt_s;
            reg_write_lat_r <= reg_write_lat_nxt_s;
            pc_src_lat_r    <= pc_src_lat_nxt_s;
        end
    end

    assign bus.out_valid     = out_valid_r;
    assign bus.out_data      = out_data_r;
    assign bus.rd_out        = rd_out_r;
    assign bus.reg_write_out = reg_write_out_r;
    assign bus.pc_src_out    = pc_src_out_r;
    assign bus.io_ack        = io_ack_r;
    assign bus.io_err        = io_err_r;
    assign bus.io_req        = busy_r;
    assign bus.stall_req     = busy_r;
endmodule

// File: tb/tb_writeback_stage_p.sv
// Self-checking bench for writeback_stage_p: directed and randomized steps
// compared against a transaction-level model of the writeback rules.
module tb_writeback_stage_p;
    localparam int W     = 32;
    localparam int NSRC  = 3;
    localparam int SEL_W = 2;
    localparam int RD_W  = 32;
    localparam int T     = 4;

    localparam int K_NONE    = 0;
    localparam int K_ABORT   = 1;
    localparam int K_DATA    = 2;
    localparam int K_TIMEOUT = 3;

    logic clk;
    logic rst;

    writeback_stage_p_if #(.WIDTH(W), .NSRC(NSRC), .SEL_W(SEL_W), .RD_W(RD_W)) bus ();

    writeback_stage_p #(
        .WIDTH(W), .NSRC(NSRC), .SEL_W(SEL_W), .RD_W(RD_W), .IO_TIMEOUT(T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model state observable at the outputs
    logic [W-1:0]    last_data = '0;
    logic [RD_W-1:0] last_rd   = '0;
    bit              rd_known  = 1'b1;
    bit              err_exp   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_sel(input int sel, input logic [NSRC*W-1:0] s);
        if (sel < NSRC) return s[sel*W +: W];
        return '0;
    endfunction

    function automatic logic [NSRC*W-1:0] rand_srcs();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic chk_idle_hold(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".reg_write_out"}, 64'(bus.reg_write_out), 64'd0);
        chk({tag, ".pc_src_out"}, 64'(bus.pc_src_out), 64'd0);
        chk({tag, ".out_data_hold"}, 64'(bus.out_data), 64'(last_data));
        if (rd_known) chk({tag, ".rd_out_hold"}, 64'(bus.rd_out), 64'(last_rd));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".out_data"}, 64'(bus.out_data), 64'd0);
        chk({tag, ".rd_out"}, 64'(bus.rd_out), 64'd0);
        chk({tag, ".reg_write_out"}, 64'(bus.reg_write_out), 64'd0);
        chk({tag, ".pc_src_out"}, 64'(bus.pc_src_out), 64'd0);
        chk({tag, ".io_req"}, 64'(bus.io_req), 64'd0);
        chk({tag, ".io_ack"}, 64'(bus.io_ack), 64'd0);
        chk({tag, ".stall_req"}, 64'(bus.stall_req), 64'd0);
        chk({tag, ".io_err"}, 64'(bus.io_err), 64'd0);
    endtask

    // One non-IO cycle; io_valid is toggled randomly because IDLE must ignore it.
    task automatic step_nonio(input string tag, input bit iv, input bit fl, input int sel,
                              input logic [NSRC*W-1:0] srcs, input logic [RD_W-1:0] r,
                              input bit rw, input bit pc);
        bit acc;
        bus.in_valid   = iv;
        bus.flush      = fl;
        bus.io_flag    = 1'b0;
        bus.mem_to_reg = SEL_W'(sel);
        bus.src_data   = srcs;
        bus.rd         = r;
        bus.reg_write  = rw;
        bus.pc_src     = pc;
        bus.io_valid   = 1'($urandom_range(0, 1));
        bus.io_data    = $urandom;
        tick();
        acc = iv && !fl;
        if (acc) begin
            last_data = ref_sel(sel, srcs);
            last_rd   = r;
            rd_known  = 1'b1;
            chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, ".out_data"}, 64'(bus.out_data), 64'(last_data));
            chk({tag, ".rd_out"}, 64'(bus.rd_out), 64'(r));
            chk({tag, ".reg_write_out"}, 64'(bus.reg_write_out), 64'(rw));
            chk({tag, ".pc_src_out"}, 64'(bus.pc_src_out), 64'(pc));
        end else begin
            chk_idle_hold(tag);
        end
        chk({tag, ".stall_req"}, 64'(bus.stall_req), 64'd0);
        chk({tag, ".io_req"}, 64'(bus.io_req), 64'd0);
        chk({tag, ".io_ack"}, 64'(bus.io_ack), 64'd0);
        chk({tag, ".io_err"}, 64'(bus.io_err), 64'(err_exp));
    endtask

    // IO read transaction. c counts cycles spent in IO_WAIT (0 = first).
    // io_valid is offered when c == delay, flush when c == flush_at.
    task automatic run_io(input string tag, input int delay, input int flush_at,
                          input logic [W-1:0] d, input logic [RD_W-1:0] r,
                          input bit rw, input bit pc);
        int  kind;
        bit  done;
        bus.in_valid   = 1'b1;
        bus.flush      = 1'b0;
        bus.io_flag    = 1'b1;
        bus.mem_to_reg = SEL_W'($urandom_range(0, 3));
        bus.src_data   = rand_srcs();
        bus.rd         = r;
        bus.reg_write  = rw;
        bus.pc_src     = pc;
        bus.io_valid   = 1'b0;
        tick();
        chk_idle_hold({tag, ".accept"});
        chk({tag, ".accept.io_req"}, 64'(bus.io_req), 64'd1);
        chk({tag, ".accept.stall_req"}, 64'(bus.stall_req), 64'd1);
        bus.in_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < T && !done; c++) begin
            bus.flush    = (c == flush_at);
            bus.io_valid = (c == delay);
            bus.io_data  = (c == delay) ? d : W'($urandom);
            if (c == flush_at)   kind = K_ABORT;
            else if (c == delay) kind = K_DATA;
            else if (c == T - 1) kind = K_TIMEOUT;
            else                 kind = K_NONE;
            tick();
            case (kind)
                K_NONE: begin
                    chk({tag, ".wait.io_req"}, 64'(bus.io_req), 64'd1);
                    chk({tag, ".wait.stall_req"}, 64'(bus.stall_req), 64'd1);
                    chk({tag, ".wait.io_ack"}, 64'(bus.io_ack), 64'd0);
                    chk_idle_hold({tag, ".wait"});
                end
                K_ABORT: begin
                    chk({tag, ".flush.io_ack"}, 64'(bus.io_ack), 64'd0);
                    chk_idle_hold({tag, ".flush"});
                end
                K_DATA: begin
                    last_data = d;
                    last_rd   = r;
                    rd_known  = 1'b1;
                    chk({tag, ".data.out_valid"}, 64'(bus.out_valid), 64'd1);
                    chk({tag, ".data.out_data"}, 64'(bus.out_data), 64'(d));
                    chk({tag, ".data.rd_out"}, 64'(bus.rd_out), 64'(r));
                    chk({tag, ".data.reg_write_out"}, 64'(bus.reg_write_out), 64'(rw));
                    chk({tag, ".data.pc_src_out"}, 64'(bus.pc_src_out), 64'(pc));
                    chk({tag, ".data.io_ack"}, 64'(bus.io_ack), 64'd1);
                end
                default: begin
                    err_exp   = 1'b1;
                    last_data = '0;
                    rd_known  = 1'b0;
                    chk({tag, ".tmo.out_valid"}, 64'(bus.out_valid), 64'd1);
                    chk({tag, ".tmo.out_data"}, 64'(bus.out_data), 64'd0);
                    chk({tag, ".tmo.reg_write_out"}, 64'(bus.reg_write_out), 64'd0);
                    chk({tag, ".tmo.pc_src_out"}, 64'(bus.pc_src_out), 64'(pc));
                    chk({tag, ".tmo.io_ack"}, 64'(bus.io_ack), 64'd0);
                end
            endcase
            if (kind != K_NONE) begin
                done = 1'b1;
                chk({tag, ".end.io_req"}, 64'(bus.io_req), 64'd0);
                chk({tag, ".end.stall_req"}, 64'(bus.stall_req), 64'd0);
            end
            chk({tag, ".io_err"}, 64'(bus.io_err), 64'(err_exp));
        end
        bus.flush    = 1'b0;
        bus.io_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.io_valid = 1'b0;
        tick();
        last_data = '0;
        last_rd   = '0;
        rd_known  = 1'b1;
        err_exp   = 1'b0;
        chk_reset_outputs("reset");
        rst = 1'b0;
    endtask

    initial begin
        logic [NSRC*W-1:0] s;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.reg_write  = 1'b0;
        bus.io_flag    = 1'b0;
        bus.mem_to_reg = '0;
        bus.src_data   = '0;
        bus.rd         = '0;
        bus.flush      = 1'b0;
        bus.io_data    = '0;
        bus.io_valid   = 1'b0;
        tick();
        do_reset();

        // source select, including an out-of-range selector
        s = rand_srcs();
        s[W +: W] = 32'h0000_00AB;
        step_nonio("sel1", 1'b1, 1'b0, 1, s, 32'd7, 1'b1, 1'b0);
        step_nonio("sel3", 1'b1, 1'b0, 3, rand_srcs(), 32'd7, 1'b1, 1'b1);

        // back-to-back accepts
        for (int k = 0; k < 3; k++) begin
            step_nonio($sformatf("b2b%0d", k), 1'b1, 1'b0, k, rand_srcs(),
                       RD_W'($urandom), 1'($urandom), 1'($urandom));
        end

        // flushed instruction in IDLE is dropped
        step_nonio("drop", 1'b1, 1'b1, 1, rand_srcs(), 32'd9, 1'b1, 1'b1);

        // IO handshake: data on the third IO_WAIT cycle
        run_io("io_hs", 2, 99, 32'h0000_1234, 32'd4, 1'b1, 1'b1);
        step_nonio("after_io", 1'b1, 1'b0, 0, rand_srcs(), 32'd5, 1'b1, 1'b0);

        // minimum IO latency and completion followed by an immediate accept
        run_io("io_fast", 0, 99, W'($urandom), 32'd11, 1'b0, 1'b1);
        step_nonio("io_fast_next", 1'b1, 1'b0, 2, rand_srcs(), 32'd12, 1'b1, 1'b1);

        // flush beats io_valid; io_valid beats timeout
        run_io("io_flush_valid", 1, 1, W'($urandom), 32'd3, 1'b1, 1'b1);
        step_nonio("post_flush", 1'b0, 1'b0, 0, rand_srcs(), 32'd0, 1'b0, 1'b0);
        run_io("io_last_cycle", T - 1, 99, 32'hCAFE_F00D, 32'd21, 1'b1, 1'b0);

        // timeout sets the sticky error
        run_io("io_timeout", 99, 99, '0, 32'd6, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step_nonio($sformatf("sticky%0d", k), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)), rand_srcs(), RD_W'($urandom),
                       1'($urandom), 1'($urandom));
        end
        do_reset();

        // randomized mix of non-IO and IO transactions
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_io($sformatf("rio%0d", k), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 7)), W'($urandom), RD_W'($urandom),
                       1'($urandom), 1'($urandom));
            end else begin
                step_nonio($sformatf("rnio%0d", k), 1'($urandom_range(0, 3) != 0),
                           1'($urandom_range(0, 4) == 0), int'($urandom_range(0, 3)),
                           rand_srcs(), RD_W'($urandom), 1'($urandom), 1'($urandom));
            end
        end

        // reset in the middle of an IO read
        bus.in_valid   = 1'b1;
        bus.flush      = 1'b0;
        bus.io_flag    = 1'b1;
        bus.rd         = 32'd13;
        bus.reg_write  = 1'b1;
        bus.pc_src     = 1'b1;
        bus.io_valid   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("midrst.pre.io_req", 64'(bus.io_req), 64'd1);
        tick();
        do_reset();
        step_nonio("midrst.post", 1'b1, 1'b0, 1, rand_srcs(), 32'd8, 1'b1, 1'b1);
        step_nonio("midrst.idle", 1'b0, 1'b0, 0, rand_srcs(), 32'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
